// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg : shared UART state encoding, bit-timing helpers, param checks    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  function automatic int count_width(input int cpb);
    return 1 + $clog2(cpb);
  endfunction

  function automatic bit params_ok(input int clk_hz, input int bit_rate,
                                   input int payload_bits, input int stop_bits);
    bit ok;
    ok = 1'b1;
    if (bit_rate <= 0) ok = 1'b0;
    else if ((clk_hz / bit_rate) < 2) ok = 1'b0;
    if ((payload_bits < 5) || (payload_bits > 9)) ok = 1'b0;
    if ((stop_bits < 1) || (stop_bits > 2)) ok = 1'b0;
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_bit_timer : per-bit cycle counter with a one-cycle bit_end strobe     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 2,
  parameter int CNT_W          = count_width(CYCLES_PER_BIT)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_end_o
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CYCLES_PER_BIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    bit_end_o = enable_i && !clear_i && (count_q == LAST_COUNT);
    count_d   = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = bit_end_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx : UART transmitter, start/LSB-first data/stop framing plus BREAK   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_tx_en,
  input  logic                    uart_tx_valid,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_tx_break,
  output logic                    uart_tx_ready,
  output logic                    uart_tx_busy,
  output logic                    uart_txd
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  // Wide enough to also count the full break length in bit times.
  localparam int BIT_CNT_W = $clog2(PAYLOAD_BITS + STOP_BITS + 1);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA  = BIT_CNT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP  = BIT_CNT_W'(STOP_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BREAK = BIT_CNT_W'(PAYLOAD_BITS + STOP_BITS);

  generate
    if (!params_ok(CLK_HZ, BIT_RATE, PAYLOAD_BITS, STOP_BITS)) begin : g_param_error
      $error("uart_tx: illegal BIT_RATE/CLK_HZ/PAYLOAD_BITS/STOP_BITS combination");
    end
  endgenerate

  uart_state_e             state_q;
  logic [PAYLOAD_BITS-1:0] shift_q;
  logic [BIT_CNT_W-1:0]    bit_cnt_q;
  logic                    txd_q;
  logic                    w_timer_clear;
  logic                    w_bit_end;

  assign w_timer_clear = (state_q == ST_IDLE);
  assign uart_tx_ready = (state_q == ST_IDLE) && uart_tx_en && !uart_tx_break;
  assign uart_tx_busy  = (state_q != ST_IDLE);
  assign uart_txd      = txd_q;

  uart_bit_timer #(
    .CYCLES_PER_BIT (CYCLES_PER_BIT)
  ) u_bit_timer (
    .clk_i     (clk),
    .rst_ni    (resetn),
    .clear_i   (w_timer_clear),
    .enable_i  (!w_timer_clear),
    .bit_end_o (w_bit_end)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          txd_q     <= 1'b1;
          bit_cnt_q <= '0;
          if (uart_tx_break && uart_tx_en) begin
            state_q <= ST_BREAK;
            txd_q   <= 1'b0;
          end else if (uart_tx_valid && uart_tx_ready) begin
            state_q <= ST_START;
            shift_q <= uart_tx_data;
            txd_q   <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            state_q <= ST_DATA;
            txd_q   <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == LAST_DATA) begin
              state_q   <= ST_STOP;
              txd_q     <= 1'b1;
              bit_cnt_q <= '0;
            end else begin
              // shift_q[1] is the bit that becomes shift_q[0] after this edge.
              txd_q     <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (bit_cnt_q == LAST_STOP) begin
              state_q   <= ST_IDLE;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        ST_BREAK: begin
          if (w_bit_end) begin
            if (bit_cnt_q == LAST_BREAK) begin
              state_q   <= ST_STOP;
              txd_q     <= 1'b1;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx : line-level model of uart_tx (8N1 and 7-data/2-stop builds)    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_uart_tx;

  localparam int CPB = 10;

  typedef bit line_t[$];

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       en_a, valid_a, brk_a, ready_a, busy_a, txd_a;
  logic [7:0] data_a;
  logic       en_b, valid_b, brk_b, ready_b, busy_b, txd_b;
  logic [6:0] data_b;

  uart_tx #(.BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .resetn(resetn), .uart_tx_en(en_a), .uart_tx_valid(valid_a),
    .uart_tx_data(data_a), .uart_tx_break(brk_a), .uart_tx_ready(ready_a),
    .uart_tx_busy(busy_a), .uart_txd(txd_a));

  uart_tx #(.BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(7), .STOP_BITS(2)) dut_b (
    .clk(clk), .resetn(resetn), .uart_tx_en(en_b), .uart_tx_valid(valid_b),
    .uart_tx_data(data_b), .uart_tx_break(brk_b), .uart_tx_ready(ready_b),
    .uart_tx_busy(busy_b), .uart_txd(txd_b));

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%b expected=%b", nm, $time, act, exp);
    end
  endfunction

  function automatic void chkn(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp);
    end
  endfunction

  // Line level for every cycle after acceptance: start, data LSB first, stops.
  function automatic line_t frame_wave(input int p, input int s, input logic [8:0] d);
    line_t w;
    for (int c = 0; c < CPB; c++) w.push_back(1'b0);
    for (int i = 0; i < p; i++)
      for (int c = 0; c < CPB; c++) w.push_back(d[i]);
    for (int c = 0; c < s * CPB; c++) w.push_back(1'b1);
    return w;
  endfunction

  function automatic line_t break_wave(input int p, input int s);
    line_t w;
    for (int c = 0; c < (1 + p + s) * CPB; c++) w.push_back(1'b0);
    for (int c = 0; c < s * CPB; c++) w.push_back(1'b1);
    return w;
  endfunction

  line_t q_a;
  line_t q_b;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (q_a.size() != 0) void'(q_a.pop_front());
      else if (en_a && brk_a) q_a = break_wave(8, 1);
      else if (en_a && valid_a) q_a = frame_wave(8, 1, {1'b0, data_a});
      if (q_b.size() != 0) void'(q_b.pop_front());
      else if (en_b && brk_b) q_b = break_wave(7, 2);
      else if (en_b && valid_b) q_b = frame_wave(7, 2, {2'b00, data_b});
    end
  end

  always @(negedge clk) begin
    chk1("txd_a",   txd_a,   (q_a.size() != 0) ? q_a[0] : 1'b1);
    chk1("busy_a",  busy_a,  q_a.size() != 0);
    chk1("ready_a", ready_a, (q_a.size() == 0) && en_a && !brk_a);
    chk1("txd_b",   txd_b,   (q_b.size() != 0) ? q_b[0] : 1'b1);
    chk1("busy_b",  busy_b,  q_b.size() != 0);
    chk1("ready_b", ready_b, (q_b.size() == 0) && en_b && !brk_b);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int   busy_cnt;
  int   low_cnt;
  logic [9:0] rx;
  logic [9:0] exp_a5;

  initial begin
    en_a = 1'b1; valid_a = 1'b0; brk_a = 1'b0; data_a = '0;
    en_b = 1'b1; valid_b = 1'b0; brk_b = 1'b0; data_b = '0;
    exp_a5 = 10'b1_10100101_0;

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_txd", txd_a, 1'b1);
    chk1("rst_busy", busy_a, 1'b0);
    chk1("rst_ready", ready_a, 1'b1);
    resetn = 1'b1;
    step(2);

    // 0xA5: 0, 1,0,1,0,0,1,0,1, 1 - each level 10 cycles
    data_a = 8'hA5; valid_a = 1'b1;
    step(1);
    valid_a = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (c % 10 == 5) chk1($sformatf("a5_bit%0d", c / 10), txd_a, exp_a5[c / 10]);
      busy_cnt += int'(busy_a);
      step(1);
    end
    chkn("a5_busy_cycles", busy_cnt, 100);
    chk1("a5_ready_after", ready_a, 1'b1);

    // Back-to-back 0x00 then 0xFF with valid held
    data_a = 8'h00; valid_a = 1'b1;
    step(1);
    data_a = 8'hFF;
    busy_cnt = 0;
    for (int c = 0; c < 220; c++) begin
      if (c == 150) valid_a = 1'b0;
      if (c == 5)   chk1("b2b_start1", txd_a, 1'b0);
      if (c == 15)  chk1("b2b_bit0_00", txd_a, 1'b0);
      if (c == 105) chk1("b2b_start2", txd_a, 1'b0);
      if (c == 115) chk1("b2b_bit0_ff", txd_a, 1'b1);
      busy_cnt += int'(busy_a);
      step(1);
    end
    chkn("b2b_busy_cycles", busy_cnt, 200);

    // Break beats a pending word; word goes out afterwards
    brk_a = 1'b1; valid_a = 1'b1; data_a = 8'h3C;
    #1;
    chk1("brk_ready_low", ready_a, 1'b0);
    step(1);
    brk_a = 1'b0;
    low_cnt = 0;
    for (int c = 0; c < 230; c++) begin
      if (c == 150) valid_a = 1'b0;
      if (c == 50)  chk1("brk_mid_low", txd_a, 1'b0);
      if (c == 105) chk1("brk_stop_high", txd_a, 1'b1);
      low_cnt += int'(!txd_a);
      step(1);
    end
    chkn("brk_low_cycles", low_cnt, 150);

    // Reset during data bit 4 of 0x55
    data_a = 8'h55; valid_a = 1'b1;
    step(1);
    valid_a = 1'b0;
    step(54);
    #2;
    resetn = 1'b0;
    #1;
    chk1("rst_mid_txd", txd_a, 1'b1);
    chk1("rst_mid_busy", busy_a, 1'b0);
    step(1);
    resetn = 1'b1;
    low_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 150; c++) begin
      low_cnt += int'(!txd_a);
      busy_cnt += int'(busy_a);
      step(1);
    end
    chkn("rst_residual_low", low_cnt, 0);
    chkn("rst_residual_busy", busy_cnt, 0);

    // Enable gating
    en_a = 1'b0; valid_a = 1'b1; data_a = 8'hAA;
    #1;
    chk1("en_ready_low", ready_a, 1'b0);
    low_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      low_cnt += int'(!txd_a);
      step(1);
    end
    chkn("en_off_low", low_cnt, 0);
    data_a = 8'h81; en_a = 1'b1;
    step(1);
    valid_a = 1'b0;
    low_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 120; c++) begin
      if (c == 20) en_a = 1'b0;
      low_cnt += int'(!txd_a);
      busy_cnt += int'(busy_a);
      step(1);
    end
    chkn("en_drop_low", low_cnt, 70);
    chkn("en_drop_busy", busy_cnt, 100);
    en_a = 1'b1;

    // 7 data bits, 2 stop bits: 0x7F with line-level loopback sampling
    data_b = 7'h7F; valid_b = 1'b1;
    step(1);
    valid_b = 1'b0;
    rx = '0;
    busy_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (c % 10 == 5) rx[c / 10] = txd_b;
      busy_cnt += int'(busy_b);
      step(1);
    end
    chk1("b_start", rx[0], 1'b0);
    chkn("b_data", int'(rx[7:1]), 32'h7F);
    chkn("b_stops", int'(rx[9:8]), 3);
    chkn("b_busy_cycles", busy_cnt, 100);

    step(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
